sms_cart_ctrl: RTL and testbench
================================

// Module: sms_cart_ctrl
// PURPOSE
//  Cartridge controller for the Master System board. Decodes Z80 cart cycles: CE3 low, MREQ low, RD or WR low.
//  Applies the Sega mapper, with bank registers at FFFC-FFFF, and turns cart cycles into req/ack accesses on one
//  single-port external memory. That memory holds the ROM image and the battery cart RAM. The same memory port is
//  shared with a host loader. The block drives DATA_o/DATA_d into the board data-bus mux in place of cart_data/cart_data_en.
// PARAMETERS
//  ROM_AW   19       ROM address width in bytes (2^ROM_AW ROM size); bank numbers are masked to ROM_AW-14 bits
//  MEM_AW   22       external memory byte-address width
//  RAM_BASE 22'h3F8000  memory byte address of cart RAM (32 KB, two 16 KB banks)
// PORTS
//  MCLK       in   1       system clock (all logic on posedge)
//  RESET      in   1       asynchronous reset, active low
//  ADDRESS    in   16      Z80 address bus
//  DATA_i     in   8       Z80 data bus (resolved)
//  MREQ,RD,WR in   1 each  Z80 strobes, active low
//  CE3        in   1       cart chip-enable from I/O chip, active low
//  DATA_o     out  8       read data to bus
//  DATA_d     out  1       1 = not driving; 0 = DATA_o valid on bus
//  host_wr    in   1       host loader write strobe (one-cycle pulse)
//  host_addr  in   MEM_AW  host write byte address
//  host_data  in   8       host write data
//  host_busy  out  1       1 while a host write is pending or in progress
//  mem_req    out  1       memory request, held until mem_ack
//  mem_we     out  1       1 = write, 0 = read; stable while mem_req
//  mem_addr   out  MEM_AW  memory byte address; stable while mem_req
//  mem_wdata  out  8       write data; stable while mem_req
//  mem_ack    in   1       one-cycle completion; mem_rdata valid in the same cycle
//  mem_rdata  in   8       read data
// BEHAVIOUR
//  Reset (async, RESET=0): FFFC=8'h00, FFFD=0, FFFE=1, FFFF=2; FSM=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
//   DATA_o=0, DATA_d=1, host_busy=0; served=0; host pending=0. If reset falls mid-access, mem_req drops immediately
//   and a late mem_ack is ignored.
//  Mapper: a write cycle with MREQ=0, WR=0 and ADDRESS>=FFFC updates the register once per cycle, on the first MCLK
//   WR is seen low. The write is independent of CE3; system RAM still takes the write elsewhere.
//   FFFC bit3 = cart RAM enable in slot 2, bit2 = RAM bank; other bits are stored but unused.
//  Translation (cart cycle, A = ADDRESS):
//   A<0400                   -> rom 0000+A (first 1 KB fixed)
//   A<4000                   -> rom {FFFD,A[13:0]}
//   A<8000                   -> rom {FFFE,A[13:0]}
//   A<C000, FFFC[3]=1        -> RAM_BASE+{FFFC[2],A[13:0]}
//   A<C000, FFFC[3]=0        -> rom {FFFF,A[13:0]}
//   A>=C000                  -> no cart access
//   The bank field is masked to ROM_AW-14 bits, so large bank numbers wrap.
//  Cycle detect: start = CE3=0 & MREQ=0 & (RD=0|WR=0) & ~served & A<C000. served is set on start and cleared when
//   RD=1 & WR=1, so there is exactly one memory access per Z80 cycle.
//  FSM states: IDLE, ZRD, ZWR, HWR.
//   IDLE: start&RD=0 -> ZRD. start&WR=0 to a RAM-mapped address -> ZWR. start&WR=0 to ROM -> stay IDLE with served
//    set (ROM writes are dropped). Else host pending -> HWR.
//   Z80 has priority over host when both are ready in the same cycle.
//   ZRD/ZWR/HWR: mem_req=1, address/data latched at entry; on mem_ack -> IDLE.
//   mem_req rises 1 cycle after start; read latency = start + 1 + memory wait.
//  Read data: on ZRD ack, DATA_o<=mem_rdata. DATA_d=0 from the next cycle while RD=0 & served; DATA_d=1 the cycle
//   after RD rises.
//  Host: host_wr latches addr/data and sets pending and host_busy the next cycle. host_busy clears on the HWR ack.
//   host_wr while busy is ignored (the host must poll host_busy).
//  An aborted Z80 cycle (RD/WR rise before ack) lets the access complete. DATA_d stays 1 and the data is discarded.
// TESTING
//  1) Reset, read 0x0100 with mem_ack 3 cycles after req -> mem_addr=0x00100, mem_we=0, DATA_d=0 with DATA_o=rdata.
//  2) Write FFFE=0x05, read 0x4123 -> mem_addr=0x14123; exactly one mem_req per RD pulse.
//  3) ROM_AW=17: write FFFF=0x1D, read 0x8000 -> mem_addr=0x14000 (bank masked to 5).
//  4) FFFC=0x0C, write 0xAA to 0x8010 -> mem_we=1, mem_addr=RAM_BASE+0x4010, mem_wdata=0xAA; ROM write 0x4000 -> no req.
//  5) host_wr and a Z80 read start in the same cycle -> Z80 served first, HWR next; host_busy falls after its ack.
//  6) Drop RESET during ZRD with mem_req=1 -> outputs at reset values within the same cycle; FFFE reads back as 1.

Source files
------------

// File: rtl/sms_cart_ctrl.sv
// Master System cartridge controller: Sega mapper registers, Z80 cart-cycle decode,
// and arbitration of Z80 and host-loader accesses onto one req/ack byte memory.
module sms_cart_ctrl #(
    parameter int                ROM_AW   = 19,
    parameter int                MEM_AW   = 22,
    parameter logic [MEM_AW-1:0] RAM_BASE = 'h3F8000
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [15:0]       ADDRESS,
    input  logic [7:0]        DATA_i,
    input  logic              MREQ,
    input  logic              RD,
    input  logic              WR,
    input  logic              CE3,
    output logic [7:0]        DATA_o,
    output logic              DATA_d,
    input  logic              host_wr,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [7:0]        host_data,
    output logic              host_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ZRD, ZWR, HWR} state_e;

    state_e            state_q, state_d;
    logic [7:0]        map_q [4];
    logic [7:0]        map_d [4];
    logic              map_seen_q, map_seen_d;
    logic              served_q, served_d;
    logic              valid_q, valid_d;
    logic              aborted_q, aborted_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        data_o_q, data_o_d;
    logic [MEM_AW-1:0] host_addr_q, host_addr_d;
    logic [7:0]        host_data_q, host_data_d;

    logic              map_we, start, cart_ram;
    logic [7:0]        bank_sel;
    logic [MEM_AW-1:0] cart_addr;
    logic              unused_bits;

    assign map_we   = ~MREQ & ~WR & (ADDRESS >= 16'hFFFC) & ~map_seen_q;
    assign start    = ~CE3 & ~MREQ & (~RD | ~WR) & ~served_q & (ADDRESS < 16'hC000);
    assign cart_ram = (ADDRESS[15:14] == 2'b10) & map_q[0][3];

    // Address translation; bank numbers keep only the bits that address the ROM.
    always_comb begin
        case (ADDRESS[15:14])
            2'b00:   bank_sel = map_q[1];
            2'b01:   bank_sel = map_q[2];
            default: bank_sel = map_q[3];
        endcase
        if (cart_ram)
            cart_addr = RAM_BASE + MEM_AW'({map_q[0][2], ADDRESS[13:0]});
        else if (ADDRESS[15:10] == 6'd0)
            cart_addr = MEM_AW'(ADDRESS[9:0]);
        else
            cart_addr = MEM_AW'({bank_sel[ROM_AW-15:0], ADDRESS[13:0]});
    end

    // The register takes the data present on the first edge of a write strobe only.
    always_comb begin
        map_d = map_q;
        if (map_we)
            map_d[ADDRESS[1:0]] = DATA_i;
        map_seen_d = ~WR & (map_seen_q | map_we);
    end

    // NOTE: every always_comb output gets its hold value first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        served_d    = served_q & ~(RD & WR);
        valid_d     = valid_q & ~RD;
        aborted_d   = aborted_q;
        pend_d      = pend_q;
        busy_d      = busy_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_o_d    = data_o_q;
        host_addr_d = host_addr_q;
        host_data_d = host_data_q;

        if (host_wr && !busy_q) begin
            host_addr_d = host_addr;
            host_data_d = host_data;
            pend_d      = 1'b1;
            busy_d      = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    served_d  = 1'b1;
                    aborted_d = 1'b0;
                    if (!RD) begin
                        state_d    = ZRD;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cart_addr;
                    end else if (cart_ram) begin
                        state_d     = ZWR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cart_addr;
                        mem_wdata_d = DATA_i;
                    end
                end else if (pend_q) begin
                    state_d     = HWR;
                    pend_d      = 1'b0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = host_addr_q;
                    mem_wdata_d = host_data_q;
                end
            end
            ZRD, ZWR: begin
                // A strobe that ended early still lets the access finish, but its data is dropped.
                if (RD && WR)
                    aborted_d = 1'b1;
                if (mem_ack) begin
                    state_d = IDLE;
                    if (state_q == ZRD && !aborted_q && !RD) begin
                        data_o_d = mem_rdata;
                        valid_d  = 1'b1;
                    end
                end
            end
            HWR: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            map_q[0]    <= 8'h00;
            map_q[1]    <= 8'h00;
            map_q[2]    <= 8'h01;
            map_q[3]    <= 8'h02;
            map_seen_q  <= 1'b0;
            served_q    <= 1'b0;
            valid_q     <= 1'b0;
            aborted_q   <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            data_o_q    <= 8'h00;
            host_addr_q <= '0;
            host_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            map_seen_q  <= map_seen_d;
            served_q    <= served_d;
            valid_q     <= valid_d;
            aborted_q   <= aborted_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_o_q    <= data_o_d;
            host_addr_q <= host_addr_d;
            host_data_q <= host_data_d;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign DATA_o    = data_o_q;
    assign DATA_d    = ~valid_q;
    assign host_busy = busy_q;

    assign unused_bits = ^{map_q[0][7:4], map_q[0][1:0], bank_sel};

endmodule

// File: tb/tb_sms_cart_ctrl.sv
// Randomized bench for sms_cart_ctrl: Z80 cycles and host writes are checked against a
// behavioural mapper/memory model; a memory responder acks with random wait states.
module tb_sms_cart_ctrl;
    localparam int          ROM_AW   = 17;
    localparam int          MEM_AW   = 22;
    localparam logic [21:0] RAM_BASE = 22'h3F8000;

    logic        mclk = 0, rst_n = 0;
    logic [15:0] ADDRESS = 0;
    logic [7:0]  DATA_i = 0, DATA_o;
    logic        MREQ = 1, RD = 1, WR = 1, CE3 = 1, DATA_d;
    logic        host_wr = 0, host_busy;
    logic [21:0] host_addr = 0, mem_addr;
    logic [7:0]  host_data = 0, mem_wdata, mem_rdata = 0;
    logic        mem_req, mem_we, mem_ack = 0;

    sms_cart_ctrl #(.ROM_AW(ROM_AW), .MEM_AW(MEM_AW), .RAM_BASE(RAM_BASE)) dut (
        .MCLK(mclk), .RESET(rst_n), .ADDRESS(ADDRESS), .DATA_i(DATA_i), .MREQ(MREQ),
        .RD(RD), .WR(WR), .CE3(CE3), .DATA_o(DATA_o), .DATA_d(DATA_d),
        .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data), .host_busy(host_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata));

    always #5 mclk = ~mclk;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {bit we; int addr; logic [7:0] data;} exp_t;
    exp_t        exp_q[$];
    logic [7:0]  m_reg [4] = '{8'h00, 8'h00, 8'h01, 8'h02};
    logic [7:0]  m_mem [int];
    logic [7:0]  r_mem [int];

    function automatic logic [7:0] pattern(input int a);
        return 8'(a ^ (a >> 8) ^ (a >> 16) ^ 8'h5A);
    endfunction

    function automatic logic [7:0] m_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : pattern(a);
    endfunction

    function automatic int xlate(input int a, output bit ram);
        int nb = 1 << (ROM_AW - 14);
        int off = a % 16384;
        logic [7:0] r0 = m_reg[0];
        ram = 0;
        if (a < 'h400)  return a;
        if (a < 'h4000) return (m_reg[1] % nb) * 16384 + off;
        if (a < 'h8000) return (m_reg[2] % nb) * 16384 + off;
        if (r0[3]) begin
            ram = 1;
            return int'(RAM_BASE) + (r0[2] ? 16384 : 0) + off;
        end
        return (m_reg[3] % nb) * 16384 + off;
    endfunction

    // ---------------- memory responder ----------------
    int   ack_wait = -1, r_last_w = 0, r_cnt = 0;
    bit   r_busy = 0, r_we = 0;
    int   r_addr = 0;
    logic [7:0] r_wd = 0;

    task automatic do_ack();
        if (r_we) r_mem[r_addr] = r_wd;
        else mem_rdata = r_mem.exists(r_addr) ? r_mem[r_addr] : pattern(r_addr);
        mem_ack = 1;
        r_busy  = 0;
    endtask

    always @(negedge mclk) begin
        if (mem_ack) mem_ack = 0;
        else if (r_busy) begin
            r_cnt--;
            if (r_cnt <= 0) do_ack();
        end else if (mem_req === 1'b1) begin
            r_last_w = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
            r_cnt = r_last_w; r_we = mem_we; r_addr = int'(mem_addr); r_wd = mem_wdata;
            r_busy = 1;
            if (r_cnt == 0) do_ack();
        end
    end

    // ---------------- compare process ----------------
    int   req_cnt = 0, last_addr = 0, last_lat = 0;
    logic [7:0] last_wdata = 0;
    bit   req_prev = 0;
    exp_t cur = '{we: 1'b0, addr: 0, data: 8'h00};

    always @(negedge mclk) begin
        if (rst_n !== 1'b1) req_prev = 0;
        else begin
            if (mem_req === 1'b1) begin
                if (!req_prev) begin
                    req_cnt++;
                    if (exp_q.size() == 0) fail("unexpected_req", $sformatf("req to 0x%0h, required none", mem_addr));
                    else cur = exp_q.pop_front();
                end
                check("req_we", mem_we, cur.we);
                check("req_addr", mem_addr, cur.addr);
                if (cur.we) check("req_wdata", mem_wdata, cur.data);
                last_addr = int'(mem_addr);
                last_wdata = mem_wdata;
            end
            req_prev = (mem_req === 1'b1);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while ((mem_req !== 1'b0 || r_busy || mem_ack || host_busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            @(negedge mclk);
            n++;
        end
        if (n >= 200) fail("idle_timeout", "still busy, required idle");
    endtask

    task automatic z_read(input int a);
        bit ram, cart;
        int ea, c0, lat;
        logic [7:0] exp_d;
        wait_idle();
        c0 = req_cnt; cart = (a < 'hC000); ea = xlate(a, ram); exp_d = m_rd(ea);
        if (cart) exp_q.push_back('{we: 1'b0, addr: ea, data: 8'h00});
        @(posedge mclk); #2;
        ADDRESS = 16'(a); MREQ = 0; RD = 0; CE3 = !cart;
        if (cart) begin
            lat = 0;
            do begin @(negedge mclk); lat++; end while (DATA_d !== 1'b0 && lat < 60);
            last_lat = lat;
            check("rd_DATA_d_low", DATA_d, 0);
            check("rd_DATA_o", DATA_o, exp_d);
            check("rd_latency", lat, r_last_w + 3);
            @(negedge mclk);
            check("rd_DATA_d_hold", DATA_d, 0);
        end else begin
            repeat (4) @(negedge mclk);
            check("noncart_DATA_d", DATA_d, 1);
        end
        @(posedge mclk); #2;
        RD = 1; MREQ = 1; CE3 = 1;
        @(negedge mclk); @(negedge mclk);
        check("rd_release_DATA_d", DATA_d, 1);
        wait_idle();
        check("rd_req_count", req_cnt - c0, cart ? 1 : 0);
    endtask

    task automatic z_write(input int a, input logic [7:0] d, input int hold);
        bit ram, cart, want;
        int ea, c0;
        wait_idle();
        c0 = req_cnt; cart = (a < 'hC000); ea = xlate(a, ram); want = cart && ram;
        if (a >= 'hFFFC) m_reg[a - 'hFFFC] = d;
        if (want) begin
            exp_q.push_back('{we: 1'b1, addr: ea, data: d});
            m_mem[ea] = d;
        end
        @(posedge mclk); #2;
        ADDRESS = 16'(a); DATA_i = d; MREQ = 0; WR = 0; CE3 = !cart;
        @(posedge mclk); #2;
        DATA_i = ~d;
        repeat (hold - 1) @(posedge mclk);
        #2; WR = 1; MREQ = 1; CE3 = 1;
        wait_idle();
        check("wr_req_count", req_cnt - c0, want ? 1 : 0);
    endtask

    task automatic h_write(input int a, input logic [7:0] d);
        int n = 0;
        wait_idle();
        exp_q.push_back('{we: 1'b1, addr: a, data: d});
        m_mem[a] = d;
        @(posedge mclk); #2;
        host_wr = 1; host_addr = 22'(a); host_data = d;
        @(posedge mclk); #2;
        host_addr = ~host_addr; host_data = ~d;
        @(negedge mclk);
        check("host_busy_set", host_busy, 1);
        @(posedge mclk); #2;
        host_wr = 0;
        while (host_busy !== 1'b0 && n < 50) begin @(negedge mclk); n++; end
        check("host_busy_clear", host_busy, 0);
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ram;
        int ea, ha, c0, n;
        logic [7:0] exp_d, hd;

        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_DATA_d", DATA_d, 1);
        check("rst_DATA_o", DATA_o, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_host_busy", host_busy, 0);
        repeat (2) @(negedge mclk);
        rst_n = 1;
        @(negedge mclk);
        check("post_rst_DATA_d", DATA_d, 1);
        check("post_rst_mem_req", mem_req, 0);

        // Fixed first-KB read, 3 wait cycles.
        ack_wait = 3;
        z_read('h0100);
        check("t1_addr", last_addr, 'h00100);
        check("t1_latency", last_lat, 6);
        ack_wait = -1;

        z_write('hFFFE, 8'h05, 1);
        z_read('h4123);
        check("t2_addr", last_addr, 'h14123);

        z_write('hFFFF, 8'h1D, 2);
        z_read('h8000);
        check("t3_addr_masked", last_addr, 'h14000);

        z_write('hFFFC, 8'h0C, 1);
        z_write('h8010, 8'hAA, 3);
        check("t4_ram_addr", last_addr, 'h3FC010);
        check("t4_ram_wdata", last_wdata, 8'hAA);
        z_write('h4000, 8'h55, 2);
        z_read('h8010);
        check("t4_ram_readback", DATA_o, 8'hAA);

        // Host write and Z80 read arriving together: Z80 first.
        wait_idle();
        ack_wait = 2;
        ea = xlate('h0123, ram); exp_d = m_rd(ea);
        ha = 'h00200; hd = 8'hC3;
        exp_q.push_back('{we: 1'b0, addr: ea, data: 8'h00});
        exp_q.push_back('{we: 1'b1, addr: ha, data: hd});
        m_mem[ha] = hd;
        c0 = req_cnt;
        @(posedge mclk); #2;
        ADDRESS = 16'h0123; MREQ = 0; RD = 0; CE3 = 0;
        host_wr = 1; host_addr = 22'(ha); host_data = hd;
        @(posedge mclk); #2;
        host_wr = 0;
        n = 0;
        while (DATA_d !== 1'b0 && n < 60) begin @(negedge mclk); n++; end
        check("t5_DATA_o", DATA_o, exp_d);
        check("t5_host_waits", host_busy, 1);
        @(posedge mclk); #2;
        RD = 1; MREQ = 1; CE3 = 1;
        n = 0;
        while (host_busy !== 1'b0 && n < 60) begin @(negedge mclk); n++; end
        check("t5_host_busy_clear", host_busy, 0);
        wait_idle();
        check("t5_req_count", req_cnt - c0, 2);
        ack_wait = -1;
        z_read('h0200);
        check("t5_host_data_readback", DATA_o, 8'hC3);

        // Randomized mix of mapper writes, cart reads/writes and host loads.
        for (int i = 0; i < 200; i++) begin
            int op = $urandom_range(0, 9);
            int a  = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 1) ? 'h0400 : 0) | $urandom_range(0, 15);
            logic [7:0] d = 8'($urandom);
            case (op)
                0, 1:       z_write('hFFFC + $urandom_range(0, 3), d, $urandom_range(1, 3));
                2, 3, 4, 5: z_read(a);
                6, 7:       z_write(a, d, $urandom_range(1, 4));
                default:    h_write(xlate(a & 'hBFFF, ram), d);
            endcase
        end

        // Reset while a read is in flight.
        z_write('hFFFE, 8'h06, 1);
        z_write('hFFFC, 8'h08, 1);
        z_write('h8005, 8'h77, 2);
        wait_idle();
        ack_wait = 3;
        ea = xlate('h4000, ram);
        exp_q.push_back('{we: 1'b0, addr: ea, data: 8'h00});
        @(posedge mclk); #2;
        ADDRESS = 16'h4000; MREQ = 0; RD = 0; CE3 = 0;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin @(negedge mclk); n++; end
        check("t6_req_before_reset", mem_req, 1);
        #1 rst_n = 0;
        #1;
        check("t6_mem_req", mem_req, 0);
        check("t6_mem_we", mem_we, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_wdata", mem_wdata, 0);
        check("t6_DATA_o", DATA_o, 0);
        check("t6_DATA_d", DATA_d, 1);
        check("t6_host_busy", host_busy, 0);
        RD = 1; MREQ = 1; CE3 = 1;
        @(negedge mclk);
        rst_n = 1;
        m_reg = '{8'h00, 8'h00, 8'h01, 8'h02};
        wait_idle();
        check("t6_no_late_data", DATA_d, 1);
        ack_wait = -1;
        z_read('h4000);
        check("t6_FFFE_reset_bank", last_addr, 'h04000);

        wait_idle();
        check("exp_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        fail("watchdog", "simulation time limit, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
